// File: rtl/sram_responder.sv
// Clocked slave model of an asynchronous 16-bit SRAM; `SRAM_PROTOCOL_CHECK_EN adds a sticky protocol-violation flag.
// Latency: rd_valid READ_LATENCY cycles after a stable sampled read address; writes commit when WE_n or CE_n deasserts.
// Backpressure: none, the initiator owns bus timing and rd_valid marks when driven data is good.
module sram_responder #(
  parameter int ADDR_BITS    = 14,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] sram_addr,
  inout  wire  [15:0] sram_data_bus,
  input  logic        CE_n,
  input  logic        OE_n,
  input  logic        WE_n,
  input  logic        UB_n,
  input  logic        LB_n,
  output logic        rd_valid,
  output logic        wr_strobe,
  output logic        access_err
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_VALID, WRITE} state_t;

  localparam int         DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] LAT   = 4'(READ_LATENCY);

  logic [15:0]          mem [DEPTH];
  state_t               state, state_nxt;
  logic [3:0]           cnt, cnt_nxt;
  logic [19:0]          prev_addr;
  logic [15:0]          out_reg;
  logic [ADDR_BITS-1:0] word;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [15:0]          wr_dat;
  logic                 wr_ub_n, wr_lb_n;
  logic                 rd_req, wr_req, addr_chg, load_out, commit;

  assign word     = sram_addr[ADDR_BITS-1:0];
  assign rd_req   = !CE_n && !OE_n && WE_n;
  assign wr_req   = !CE_n && !WE_n;
  assign addr_chg = (sram_addr != prev_addr);
  assign rd_valid = (state == RD_VALID);

  // Bus enable follows the raw pins so the initiator sees data without a clock of delay.
  assign sram_data_bus = (!reset && rd_req) ? out_reg : 16'hzzzz;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_out  = 1'b0;
    commit    = 1'b0;
    if (state == WRITE && !wr_req) begin
      commit = 1'b1;
      if (rd_req) begin
        state_nxt = RD_WAIT;
        cnt_nxt   = 4'd1;
      end else begin
        state_nxt = IDLE;
      end
    end else if (wr_req) begin
      state_nxt = WRITE;
    end else begin
      case (state)
        IDLE: begin
          if (rd_req) begin
            state_nxt = RD_WAIT;
            cnt_nxt   = 4'd1;
          end
        end
        RD_WAIT: begin
          if (!rd_req) begin
            state_nxt = IDLE;
          end else if (addr_chg) begin
            cnt_nxt = 4'd1;
          end else if (cnt == LAT) begin
            state_nxt = RD_VALID;
            load_out  = 1'b1;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
        RD_VALID: begin
          if (!rd_req) begin
            state_nxt = IDLE;
          end else if (addr_chg) begin
            state_nxt = RD_WAIT;
            cnt_nxt   = 4'd1;
          end else begin
            load_out = 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      out_reg   <= 16'h0000;
      wr_strobe <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      wr_strobe <= commit;
      if (load_out) begin
        out_reg <= mem[word];
      end
    end
  end

  // Last sample of a multi-cycle write wins.
  always_ff @(posedge clk) begin
    prev_addr <= sram_addr;
    if (wr_req) begin
      wr_addr <= word;
      wr_dat  <= sram_data_bus;
      wr_ub_n <= UB_n;
      wr_lb_n <= LB_n;
    end
  end

  // Storage is never cleared; a write interrupted by reset is dropped.
  always_ff @(posedge clk) begin
    if (commit && !reset) begin
      if (!wr_ub_n) begin
        mem[wr_addr][15:8] <= wr_dat[15:8];
      end
      if (!wr_lb_n) begin
        mem[wr_addr][7:0] <= wr_dat[7:0];
      end
    end
  end

`ifdef SRAM_PROTOCOL_CHECK_EN
  logic err_set;

  assign err_set = (!CE_n && !OE_n && !WE_n)
                || (state == WRITE && wr_req && addr_chg)
                || (commit && wr_ub_n && wr_lb_n);

  always_ff @(posedge clk) begin
    if (reset) begin
      access_err <= 1'b0;
    end else if (err_set) begin
      access_err <= 1'b1;
    end
  end
`else
  assign access_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: initiator drives on negedge, outputs checked on negedge.
// The bench holds a 0 on the bus whenever the responder must float, so any responder drive shows up.
// Expected values are hand-computed for ADDR_BITS=14, READ_LATENCY=2.
module tb_sram_responder;
  localparam int AB  = 14;
  localparam int LAT = 2;
`ifdef SRAM_PROTOCOL_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] addr;
  logic        ce_n, oe_n, we_n, ub_n, lb_n;
  logic        drv_en;
  logic [15:0] drv_dat;
  wire  [15:0] bus;
  wire         rd_valid, wr_strobe, access_err;
  int          total = 0;
  int          bad = 0;

  assign bus = drv_en ? drv_dat : 16'hzzzz;
  always #5 clk = ~clk;

  sram_responder #(.ADDR_BITS(AB), .READ_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .sram_addr(addr), .sram_data_bus(bus),
    .CE_n(ce_n), .OE_n(oe_n), .WE_n(we_n), .UB_n(ub_n), .LB_n(lb_n),
    .rd_valid(rd_valid), .wr_strobe(wr_strobe), .access_err(access_err)
  );

  task automatic go_idle();
    ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1; ub_n = 1'b1; lb_n = 1'b1; drv_en = 1'b0;
  endtask

  task automatic do_write(input logic [19:0] a, input logic [15:0] d, input logic ub, input logic lb);
    @(negedge clk);
    addr = a; ce_n = 1'b0; oe_n = 1'b1; we_n = 1'b0; ub_n = ub; lb_n = lb;
    drv_en = 1'b1; drv_dat = d;
    @(negedge clk);
    go_idle();
  endtask

  // lat = negedges from the current one until rd_valid, 0 on timeout.
  task automatic wait_valid(output int lat, output logic [15:0] d);
    lat = 0;
    d = 16'h0000;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rd_valid) begin
        lat = i;
        d = bus;
        break;
      end
    end
  endtask

  task automatic read_wait(input logic [19:0] a, output int lat, output logic [15:0] d);
    @(negedge clk);
    addr = a; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; drv_en = 1'b0;
    wait_valid(lat, d);
  endtask

  task automatic test_reset();
    reset = 1'b1; addr = 20'h0; drv_dat = 16'h0000;
    go_idle();
    repeat (2) @(negedge clk);
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b want=0", rd_valid); end
    total++; if (wr_strobe !== 1'b0) begin bad++; $display("FAIL reset_wr_strobe got=%b want=0", wr_strobe); end
    total++; if (access_err !== 1'b0) begin bad++; $display("FAIL reset_access_err got=%b want=0", access_err); end
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    int pulses, strobe_at, lat;
    logic [15:0] d;
    @(negedge clk);
    addr = 20'h00010; ce_n = 1'b0; oe_n = 1'b1; we_n = 1'b0; ub_n = 1'b0; lb_n = 1'b0;
    drv_en = 1'b1; drv_dat = 16'hA5C3;
    @(negedge clk);
    total++; if (wr_strobe !== 1'b0) begin bad++; $display("FAIL wr_early got=%b want=0", wr_strobe); end
    we_n = 1'b1; oe_n = 1'b0; drv_en = 1'b0;
    pulses = 0; strobe_at = 0; lat = 0; d = 16'h0000;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (wr_strobe) begin
        pulses++;
        if (strobe_at == 0) strobe_at = i;
      end
      if (rd_valid && lat == 0) begin
        lat = i;
        d = bus;
      end
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL wr_pulses got=%0d want=1", pulses); end
    total++; if (strobe_at !== 1) begin bad++; $display("FAIL wr_strobe_cycle got=%0d want=1", strobe_at); end
    total++; if (lat !== LAT + 1) begin bad++; $display("FAIL rd_latency got=%0d want=%0d", lat, LAT + 1); end
    total++; if (d !== 16'hA5C3) begin bad++; $display("FAIL rd_data got=%h want=a5c3", d); end
  endtask

  task automatic test_byte_lanes();
    int lat;
    logic [15:0] d;
    do_write(20'h00020, 16'h1234, 1'b0, 1'b0);
    do_write(20'h00020, 16'hFFFF, 1'b1, 1'b0);
    read_wait(20'h00020, lat, d);
    total++; if (d !== 16'h12FF) begin bad++; $display("FAIL lower_lane got=%h want=12ff", d); end
    do_write(20'h00020, 16'h5600, 1'b0, 1'b1);
    read_wait(20'h00020, lat, d);
    total++; if (d !== 16'h56FF) begin bad++; $display("FAIL upper_lane got=%h want=56ff", d); end
  endtask

  task automatic test_addr_change();
    int lat;
    logic [15:0] d;
    do_write(20'h00011, 16'hBEEF, 1'b0, 1'b0);
    read_wait(20'h00010, lat, d);
    total++; if (d !== 16'hA5C3) begin bad++; $display("FAIL chg_first got=%h want=a5c3", d); end
    addr = 20'h00011;
    @(negedge clk);
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL chg_drop got=%b want=0", rd_valid); end
    wait_valid(lat, d);
    total++; if (lat !== LAT) begin bad++; $display("FAIL chg_latency got=%0d want=%0d", lat, LAT); end
    total++; if (d !== 16'hBEEF) begin bad++; $display("FAIL chg_data got=%h want=beef", d); end
  endtask

  task automatic test_alias_float();
    int lat;
    logic [15:0] d;
    read_wait(20'h04010, lat, d);
    total++; if (lat !== LAT + 1) begin bad++; $display("FAIL alias_latency got=%0d want=%0d", lat, LAT + 1); end
    total++; if (d !== 16'hA5C3) begin bad++; $display("FAIL alias_data got=%h want=a5c3", d); end
    oe_n = 1'b1; drv_en = 1'b1; drv_dat = 16'h0000;
    #1;
    total++; if (bus !== 16'h0000) begin bad++; $display("FAIL oe_float got=%h want=0000", bus); end
    @(negedge clk);
    go_idle();
  endtask

  task automatic test_reset_mid_write();
    int lat;
    logic [15:0] d;
    do_write(20'h00030, 16'h0BAD, 1'b0, 1'b0);
    @(negedge clk);
    addr = 20'h00030; ce_n = 1'b0; oe_n = 1'b1; we_n = 1'b0; ub_n = 1'b0; lb_n = 1'b0;
    drv_en = 1'b1; drv_dat = 16'h5555;
    @(negedge clk);
    reset = 1'b1; we_n = 1'b1; oe_n = 1'b0; drv_dat = 16'h0000;
    #1;
    total++; if (bus !== 16'h0000) begin bad++; $display("FAIL reset_float got=%h want=0000", bus); end
    @(negedge clk);
    total++; if (wr_strobe !== 1'b0) begin bad++; $display("FAIL rst_wr_strobe got=%b want=0", wr_strobe); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid got=%b want=0", rd_valid); end
    total++; if (access_err !== 1'b0) begin bad++; $display("FAIL rst_access_err got=%b want=0", access_err); end
    reset = 1'b0; drv_en = 1'b0;
    #1;
    total++; if (bus !== 16'h0000) begin bad++; $display("FAIL rst_out_reg got=%h want=0000", bus); end
    wait_valid(lat, d);
    total++; if (d !== 16'h0BAD) begin bad++; $display("FAIL rst_mem_kept got=%h want=0bad", d); end
  endtask

  task automatic test_protocol();
    int lat;
    logic [15:0] d;
    @(negedge clk);
    addr = 20'h00040; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b0; ub_n = 1'b0; lb_n = 1'b0;
    drv_en = 1'b1; drv_dat = 16'h7777;
    #1;
    total++; if (bus !== 16'h7777) begin bad++; $display("FAIL combined_float got=%h want=7777", bus); end
    @(negedge clk);
    go_idle();
    repeat (2) @(negedge clk);
    total++; if (access_err !== EXP_ERR) begin bad++; $display("FAIL err_held got=%b want=%b", access_err, EXP_ERR); end
    read_wait(20'h00040, lat, d);
    total++; if (d !== 16'h7777) begin bad++; $display("FAIL combined_write got=%h want=7777", d); end
    @(negedge clk);
    reset = 1'b1;
    go_idle();
    @(negedge clk);
    total++; if (access_err !== 1'b0) begin bad++; $display("FAIL err_cleared got=%b want=0", access_err); end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_addr_change();
    test_alias_float();
    test_reset_mid_write();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 14; number of implemented address bits, giving a depth of 2^ADDR_BITS x 16-bit words.
REQ-002 SHALL have parameter READ_LATENCY, default 2; clk cycles from start of a stable read address to valid data (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port sram_addr  input  20  word address from the SRAM initiator.
REQ-006 SHALL have port sram_data_bus  inout  16  bidirectional data bus.
REQ-007 SHALL have ports CE_n, OE_n, WE_n  input  1 each  chip, output and write enables, active-low.
REQ-008 SHALL have ports UB_n, LB_n  input  1 each  upper byte [15:8] and lower byte [7:0] enables, active-low.
REQ-009 SHALL have port rd_valid  output  1  high while driven read data meets READ_LATENCY.
REQ-010 SHALL have port wr_strobe  output  1  one-cycle pulse on each write commit.
REQ-011 SHALL have port access_err  output  1  sticky protocol-violation flag.

Function
REQ-012 SHALL hold storage of 2^ADDR_BITS words indexed by sram_addr[ADDR_BITS-1:0]; upper address bits are ignored, so addresses alias.
REQ-013 SHALL sample all initiator inputs on posedge clk with no synchroniser; the initiator changes them on negedge clk.
REQ-014 SHALL use FSM states IDLE, RD_WAIT, RD_VALID, WRITE.
REQ-015 SHALL move IDLE->RD_WAIT on a sampled read (CE_n=0, OE_n=0, WE_n=1) and load the latency counter with 1.
REQ-016 SHALL increment the counter each RD_WAIT cycle and go RD_WAIT->RD_VALID when the counter equals READ_LATENCY, capturing mem[addr] into the output register on that transition.
REQ-017 SHALL return from RD_VALID or RD_WAIT to RD_WAIT with the counter at 1 when the sampled address differs from the previous sample.
REQ-018 SHALL, in RD_VALID, refresh the output register every cycle so that same-address writes from other sources stay coherent.
REQ-019 SHALL drive sram_data_bus from the output register combinationally whenever raw CE_n=0, OE_n=0 and WE_n=1, and float it otherwise; data in RD_WAIT is the previous register value.
REQ-020 SHALL drive rd_valid high only in RD_VALID.
REQ-021 SHALL move to WRITE from any state on a sampled CE_n=0 and WE_n=0, and capture address, data and UB_n/LB_n every WRITE cycle, with the last sample winning.
REQ-022 SHALL commit the captured write when WRITE samples WE_n=1 or CE_n=1: bits [15:8] are written if the captured UB_n=0, bits [7:0] if LB_n=0, and wr_strobe pulses in that cycle.
REQ-023 SHALL make a commit visible to reads from the next cycle.
REQ-024 SHALL leave WRITE on commit to RD_WAIT (counter 1) if a read is sampled, otherwise to IDLE.
REQ-025 SHALL return any state to IDLE on a sampled CE_n=1; in WRITE the commit of REQ-022 happens first.
REQ-026 SHALL, when CE_n=0 and OE_n=0 and WE_n=0 are sampled together, treat the cycle as a write, keeping the bus floated.

Reset
REQ-027 SHALL, on reset sampled high, enter IDLE, clear the counter, rd_valid=0, wr_strobe=0 and access_err=0, and leave the output register at 16'h0000.
REQ-028 SHALL not clear memory contents on reset, and SHALL discard without commit a write in progress when reset is asserted.
REQ-029 SHALL float the bus during reset regardless of the enables.

Configuration
REQ-030 SHALL, with SRAM_PROTOCOL_CHECK_EN defined, set access_err (held until reset) on any of: CE_n=OE_n=WE_n=0 sampled together; sram_addr changing between WRITE cycles; a commit with UB_n=LB_n=1 captured.
REQ-031 SHALL, without SRAM_PROTOCOL_CHECK_EN, tie access_err to 0 and include no check logic.

Verification
REQ-032 SHALL cover: write 16'hA5C3 to 0x00010 with UB_n=LB_n=0 (one-cycle WE_n pulse), then read 0x00010 -> wr_strobe one pulse; rd_valid high 2 cycles after read start; bus = 16'hA5C3.
REQ-033 SHALL cover: mem[0x20]=16'h1234, then write 16'hFFFF with UB_n=1, LB_n=0 -> read 0x20 returns 16'h12FF.
REQ-034 SHALL cover: during RD_VALID at 0x10, change address to 0x11 -> rd_valid drops next cycle and returns after READ_LATENCY with mem[0x11].
REQ-035 SHALL cover: address 0x4010 with ADDR_BITS=14 -> aliases 0x0010; OE_n=1 -> bus reads Z.
REQ-036 SHALL cover: reset asserted mid-write of 16'h5555 to 0x30 -> no wr_strobe, mem[0x30] unchanged, all outputs per REQ-027.
REQ-037 SHALL cover, with SRAM_PROTOCOL_CHECK_EN: CE_n=OE_n=WE_n=0 for one cycle -> access_err=1, held after inputs return idle until reset; without the macro access_err stays 0.
